// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: ROM entry layout, FSM state
// encoding and a helper that packs song entries.
package melody_pkg;

    localparam int ENTRY_W  = 12;
    localparam int END_BIT  = 11;
    localparam int REST_BIT = 10;
    localparam int DUR_MSB  = 9;
    localparam int DUR_LSB  = 7;
    localparam int RSV_MSB  = 6;
    localparam int RSV_LSB  = 4;
    localparam int NOTE_MSB = 3;
    localparam int NOTE_LSB = 0;
    localparam int DUR_W    = 3;
    localparam int NOTE_W   = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_FETCH_ENC = 2'd1;
    localparam logic [1:0] ST_TONE_ENC  = 2'd2;
    localparam logic [1:0] ST_GAP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_FETCH = ST_FETCH_ENC,
        S_TONE  = ST_TONE_ENC,
        S_GAP   = ST_GAP_ENC
    } state_e;

    typedef logic [ENTRY_W-1:0] entry_t;

    localparam entry_t ENTRY_END = 12'h800;

    // beats is the musical length 1..8; the stored field holds beats-1.
    function automatic entry_t mk_entry(logic rest, int beats, logic [NOTE_W-1:0] note_v);
        entry_t e;
        e                    = '0;
        e[REST_BIT]          = rest;
        e[DUR_MSB:DUR_LSB]   = DUR_W'(beats - 1);
        e[NOTE_MSB:NOTE_LSB] = note_v;
        return e;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song tables for the melody sequencer, selected by SONG. Read is purely
// combinational; addresses past a table's last entry read as END.
module melody_rom
    import melody_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int SONG   = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    output entry_t            entry_o
);

    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch)
    always_comb begin
        entry_o = ENTRY_END;
        case (SONG)
            0: begin
                case (int'(addr_i))
                    0:       entry_o = mk_entry(1'b0, 1, 4'h5);
                    1:       entry_o = mk_entry(1'b0, 2, 4'hA);
                    default: entry_o = ENTRY_END;
                endcase
            end
            1: begin
                case (int'(addr_i))
                    0:       entry_o = mk_entry(1'b1, 3, 4'h2);
                    1:       entry_o = mk_entry(1'b0, 8, 4'hF);
                    2:       entry_o = mk_entry(1'b0, 2, 4'h1);
                    default: entry_o = ENTRY_END;
                endcase
            end
            2: begin
                // No END anywhere: exercises the end-of-address-space stop.
                entry_o = mk_entry(1'b0, 1, NOTE_W'(addr_i));
            end
            default: begin
                case (int'(addr_i))
                    0:       entry_o = mk_entry(1'b0, 1, 4'h0);
                    1:       entry_o = mk_entry(1'b0, 1, 4'h0);
                    2:       entry_o = mk_entry(1'b0, 1, 4'h7);
                    3:       entry_o = mk_entry(1'b0, 1, 4'h7);
                    4:       entry_o = mk_entry(1'b0, 1, 4'h9);
                    5:       entry_o = mk_entry(1'b0, 1, 4'h9);
                    6:       entry_o = mk_entry(1'b0, 2, 4'h7);
                    7:       entry_o = mk_entry(1'b1, 1, 4'h0);
                    8:       entry_o = mk_entry(1'b0, 1, 4'h5);
                    9:       entry_o = mk_entry(1'b0, 1, 4'h5);
                    10:      entry_o = mk_entry(1'b0, 1, 4'h4);
                    11:      entry_o = mk_entry(1'b0, 1, 4'h4);
                    12:      entry_o = mk_entry(1'b0, 1, 4'h2);
                    13:      entry_o = mk_entry(1'b0, 1, 4'h2);
                    14:      entry_o = mk_entry(1'b0, 4, 4'h0);
                    default: entry_o = ENTRY_END;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Walks the melody ROM and drives the tone generator's note/hush inputs.
// Optional feature macro: MELODY_LOOP_EN adds the loop input (restart at END).
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25_000_000,
    parameter int GAP_TICKS      = 1_000_000,
    parameter int ADDR_W         = 5,
    parameter int SONG           = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
`ifdef MELODY_LOOP_EN
    input  logic              loop,
`endif
    output logic [3:0]        note,
    output logic              hush,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] STEP_LAST = '1;

    state_e             state_q;
    logic [3:0]         note_q;
    logic               hush_q;
    logic               busy_q;
    logic               done_q;
    logic [ADDR_W-1:0]  step_q;
    logic [DUR_W-1:0]   beats_q;
    logic [TICK_W-1:0]  tick_q;
    logic [GAP_W-1:0]   gap_q;
    logic               last_q;

    entry_t             entry;
    logic               end_hit;
    logic               loop_hit;
    logic [ADDR_W-1:0]  step_d;
    logic               last_d;
    logic               unused_reserved;

    melody_rom #(
        .ADDR_W (ADDR_W),
        .SONG   (SONG)
    ) u_rom (
        .addr_i  (step_q),
        .entry_o (entry)
    );

    // Once the top address has been played, the next fetch is forced to END.
    assign end_hit         = entry[END_BIT] | last_q;
    assign unused_reserved = ^entry[RSV_MSB:RSV_LSB];

`ifdef MELODY_LOOP_EN
    assign loop_hit = loop;
`else
    assign loop_hit = 1'b0;
`endif

    // Advance to the next entry; the address saturates instead of wrapping.
    assign last_d = (step_q == STEP_LAST);
    assign step_d = last_d ? step_q : step_q + ADDR_W'(1);

    // NOTE: all state below is written with <= so every register samples pre-edge values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            hush_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            beats_q <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                hush_q  <= 1'b1;
                busy_q  <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            step_q  <= '0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (end_hit) begin
                            if (loop_hit) begin
                                step_q <= '0;
                                last_q <= 1'b0;
                            end else begin
                                done_q  <= 1'b1;
                                hush_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            note_q  <= entry[NOTE_MSB:NOTE_LSB];
                            hush_q  <= entry[REST_BIT];
                            beats_q <= entry[DUR_MSB:DUR_LSB];
                            tick_q  <= '0;
                            state_q <= S_TONE;
                        end
                    end
                    S_TONE: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (beats_q != '0) begin
                                beats_q <= beats_q - DUR_W'(1);
                            end else if (GAP_TICKS > 0) begin
                                hush_q  <= 1'b1;
                                gap_q   <= '0;
                                state_q <= S_GAP;
                            end else begin
                                step_q  <= step_d;
                                last_q  <= last_d;
                                state_q <= S_FETCH;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            step_q  <= step_d;
                            last_q  <= last_d;
                            state_q <= S_FETCH;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign note = note_q;
    assign hush = hush_q;
    assign busy = busy_q;
    assign done = done_q;
    assign step = step_q;

endmodule
